// File: rtl/ball_motion.sv
// Ball position generator: steps the ball once per video frame, applying
// button kicks, friction, wall reflections and side-wall goal detection.
module ball_motion #(
    parameter int X_MIN           = 144,
    parameter int X_MAX           = 783,
    parameter int Y_MIN           = 35,
    parameter int Y_MAX           = 514,
    parameter int X_C             = 464,
    parameter int Y_C             = 275,
    parameter int BALL_R          = 6,
    parameter int GOAL_Y0         = 235,
    parameter int GOAL_Y1         = 315,
    parameter int KICK_V          = 4,
    parameter int FRICTION_FRAMES = 16,
    parameter int GOAL_FRAMES     = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [1:0]  btn,
    output logic [10:0] mem_X,
    output logic [10:0] mem_Y,
    output logic        pos_valid,
    output logic [1:0]  goal
);

    // Legal range for the ball centre and the mirror points used for bounces.
    localparam logic signed [11:0] XLO  = 12'(X_MIN + BALL_R);
    localparam logic signed [11:0] XHI  = 12'(X_MAX - BALL_R);
    localparam logic signed [11:0] YLO  = 12'(Y_MIN + BALL_R);
    localparam logic signed [11:0] YHI  = 12'(Y_MAX - BALL_R);
    localparam logic signed [11:0] XLO2 = 12'(2 * (X_MIN + BALL_R));
    localparam logic signed [11:0] XHI2 = 12'(2 * (X_MAX - BALL_R));
    localparam logic signed [11:0] YLO2 = 12'(2 * (Y_MIN + BALL_R));
    localparam logic signed [11:0] YHI2 = 12'(2 * (Y_MAX - BALL_R));
    localparam logic signed [11:0] GY0  = 12'(GOAL_Y0);
    localparam logic signed [11:0] GY1  = 12'(GOAL_Y1);
    localparam logic signed [11:0] XC   = 12'(X_C);
    localparam logic signed [11:0] YC   = 12'(Y_C);
    localparam logic signed [4:0]  KV   = 5'(KICK_V);
    localparam logic [15:0] FRIC_LAST   = 16'(FRICTION_FRAMES - 1);
    localparam logic [15:0] HOLD_INIT   = 16'(GOAL_FRAMES);

    typedef enum logic [2:0] {IDLE, STEP_X, STEP_Y, UPDATE, GOAL_HOLD} state_t;

    state_t             state;
    logic signed [11:0] x, y;
    logic signed [4:0]  vx, vy;
    logic [15:0]        frame_cnt;
    logic [15:0]        hold_cnt;
    logic [1:0]         kick_pend;
    logic [1:0]         btn_prev;
    logic [1:0]         goal_hit;

    logic [1:0]         kick_rise;
    logic signed [4:0]  vx_k, vy_k;
    logic signed [11:0] nx, ny;
    logic               in_band;

    // Move one unit of speed toward zero; used by friction.
    function automatic logic signed [4:0] toward_zero(input logic signed [4:0] v);
        if (v > 5'sd0)
            return v - 5'sd1;
        else if (v < 5'sd0)
            return v + 5'sd1;
        else
            return v;
    endfunction

    // Kick-adjusted velocity and candidate next positions for the step states.
    always_comb begin
        kick_rise = btn & ~btn_prev;
        vx_k = vx;
        vy_k = vy;
        if (kick_pend == 2'b01) begin
            vx_k = KV;
            vy_k = 5'sd1;
        end else if (kick_pend == 2'b10) begin
            vx_k = -KV;
            vy_k = -5'sd1;
        end
        nx = x + {{7{vx_k[4]}}, vx_k};
        ny = y + {{7{vy[4]}}, vy};
        in_band = (y >= GY0) && (y <= GY1);
    end

    // Frame-step FSM: kick capture, X move with goal check, Y move, publish.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            x         <= XC;
            y         <= YC;
            vx        <= '0;
            vy        <= '0;
            frame_cnt <= '0;
            hold_cnt  <= '0;
            kick_pend <= '0;
            btn_prev  <= '0;
            goal_hit  <= '0;
            mem_X     <= XC[10:0];
            mem_Y     <= YC[10:0];
            pos_valid <= 1'b0;
            goal      <= '0;
        end else begin
            pos_valid <= 1'b0;
            goal      <= '0;
            btn_prev  <= btn;
            if (state != GOAL_HOLD)
                kick_pend <= kick_pend | kick_rise;

            case (state)
                IDLE: begin
                    if (frame_tick)
                        state <= STEP_X;
                end
                STEP_X: begin
                    if (kick_pend != 2'b00) begin
                        kick_pend <= kick_rise;
                        if (kick_pend != 2'b11)
                            frame_cnt <= '0;
                    end
                    vx       <= vx_k;
                    vy       <= vy_k;
                    goal_hit <= '0;
                    if (nx > XHI) begin
                        if (in_band)
                            goal_hit <= 2'b01;
                        else begin
                            x  <= XHI2 - nx;
                            vx <= -vx_k;
                        end
                    end else if (nx < XLO) begin
                        if (in_band)
                            goal_hit <= 2'b10;
                        else begin
                            x  <= XLO2 - nx;
                            vx <= -vx_k;
                        end
                    end else begin
                        x <= nx;
                    end
                    state <= STEP_Y;
                end
                STEP_Y: begin
                    if (goal_hit == 2'b00) begin
                        if (ny > YHI) begin
                            y  <= YHI2 - ny;
                            vy <= -vy;
                        end else if (ny < YLO) begin
                            y  <= YLO2 - ny;
                            vy <= -vy;
                        end else begin
                            y <= ny;
                        end
                    end
                    state <= UPDATE;
                end
                UPDATE: begin
                    pos_valid <= 1'b1;
                    if (goal_hit != 2'b00) begin
                        goal      <= goal_hit;
                        goal_hit  <= '0;
                        x         <= XC;
                        y         <= YC;
                        vx        <= '0;
                        vy        <= '0;
                        kick_pend <= '0;
                        frame_cnt <= '0;
                        hold_cnt  <= HOLD_INIT;
                        mem_X     <= XC[10:0];
                        mem_Y     <= YC[10:0];
                        state     <= (GOAL_FRAMES == 0) ? IDLE : GOAL_HOLD;
                    end else begin
                        mem_X <= x[10:0];
                        mem_Y <= y[10:0];
                        if (FRICTION_FRAMES != 0 && frame_cnt == FRIC_LAST) begin
                            vx        <= toward_zero(vx);
                            vy        <= toward_zero(vy);
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                        state <= IDLE;
                    end
                end
                GOAL_HOLD: begin
                    if (frame_tick) begin
                        if (hold_cnt <= 16'd1) begin
                            hold_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            hold_cnt <= hold_cnt - 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: two instances (default parameters, and
// friction off with a wide goal band) share stimulus; a frame-level model
// predicts each published position and its arrival cycle.
module tb_ball_motion;

    localparam int XL = 150, XH = 777, YL = 41, YH = 508;
    localparam int XC = 464, YC = 275, KV = 4, GF = 60;

    typedef struct {
        int x;
        int y;
        int g;
        int cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic [1:0]  btn = 2'b00;
    logic [10:0] mx_a, my_a, mx_b, my_b;
    logic        pv_a, pv_b;
    logic [1:0]  g_a, g_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic reset_q = 1'b0;
    logic done_chk = 1'b0;
    logic done_seen = 1'b0;

    // Frame-level reference state, index 0 = dut_a, 1 = dut_b.
    int mx[2], my[2], mvx[2], mvy[2], mcnt[2], mpend[2], mhold[2];
    int ff[2]  = '{16, 0};
    int gy0[2] = '{235, 150};
    int gy1[2] = '{315, 315};

    always #5 clk = ~clk;

    ball_motion dut_a (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn(btn),
        .mem_X(mx_a), .mem_Y(my_a), .pos_valid(pv_a), .goal(g_a)
    );

    ball_motion #(.FRICTION_FRAMES(0), .GOAL_Y0(150)) dut_b (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn(btn),
        .mem_X(mx_b), .mem_Y(my_b), .pos_valid(pv_b), .goal(g_b)
    );

    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mx[d] = XC; my[d] = YC; mvx[d] = 0; mvy[d] = 0;
            mcnt[d] = 0; mpend[d] = 0; mhold[d] = 0;
        end
    endtask

    // One frame of ball physics as described for the field.
    task automatic model_tick(input int d, output bit emit, output exp_t e);
        int nx, ny, g;
        bit band;
        emit = 0;
        e = '{0, 0, 0, 0};
        if (mhold[d] > 0) begin
            mhold[d]--;
            return;
        end
        if (mpend[d] == 3) mpend[d] = 0;
        else if (mpend[d] == 1) begin
            mvx[d] = KV; mvy[d] = 1; mpend[d] = 0; mcnt[d] = 0;
        end else if (mpend[d] == 2) begin
            mvx[d] = -KV; mvy[d] = -1; mpend[d] = 0; mcnt[d] = 0;
        end
        band = (my[d] >= gy0[d]) && (my[d] <= gy1[d]);
        g = 0;
        nx = mx[d] + mvx[d];
        if (nx > XH) begin
            if (band) g = 1;
            else begin mx[d] = 2 * XH - nx; mvx[d] = -mvx[d]; end
        end else if (nx < XL) begin
            if (band) g = 2;
            else begin mx[d] = 2 * XL - nx; mvx[d] = -mvx[d]; end
        end else mx[d] = nx;
        emit = 1;
        if (g != 0) begin
            mx[d] = XC; my[d] = YC; mvx[d] = 0; mvy[d] = 0;
            mpend[d] = 0; mcnt[d] = 0; mhold[d] = GF;
            e = '{XC, YC, g, 0};
            return;
        end
        ny = my[d] + mvy[d];
        if (ny > YH) begin my[d] = 2 * YH - ny; mvy[d] = -mvy[d]; end
        else if (ny < YL) begin my[d] = 2 * YL - ny; mvy[d] = -mvy[d]; end
        else my[d] = ny;
        if (ff[d] != 0 && mcnt[d] == ff[d] - 1) begin
            if (mvx[d] > 0) mvx[d]--; else if (mvx[d] < 0) mvx[d]++;
            if (mvy[d] > 0) mvy[d]--; else if (mvy[d] < 0) mvy[d]++;
            mcnt[d] = 0;
        end else mcnt[d]++;
        e = '{mx[d], my[d], 0, 0};
    endtask

    // Issue one frame tick and queue what each instance should publish.
    task automatic applyStimulus();
        exp_t e;
        bit   em;
        @(negedge clk);
        frame_tick = 1'b1;
        for (int d = 0; d < 2; d++) begin
            model_tick(d, em, e);
            if (em) begin
                e.cyc = cyc + 4;
                if (d == 0) q_a.push_back(e);
                else        q_b.push_back(e);
            end
        end
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic setButtons(input logic [1:0] v);
        logic [1:0] rise;
        @(negedge clk);
        rise = v & ~btn;
        for (int d = 0; d < 2; d++)
            if (mhold[d] == 0) mpend[d] = mpend[d] | int'(rise);
        btn = v;
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset = 1'b1;
        btn = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Cycle counter and registered view of reset for the monitor.
    initial forever begin
        @(posedge clk);
        cyc++;
        reset_q = reset;
    end

    // Monitor: compare every published position against the scoreboard.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (reset_q) begin
            checkOutput("rst_x_a", int'(mx_a), XC);
            checkOutput("rst_y_a", int'(my_a), YC);
            checkOutput("rst_valid_a", int'(pv_a), 0);
            checkOutput("rst_goal_a", int'(g_a), 0);
            checkOutput("rst_x_b", int'(mx_b), XC);
            checkOutput("rst_y_b", int'(my_b), YC);
            checkOutput("rst_valid_b", int'(pv_b), 0);
        end else begin
            if (pv_a) begin
                if (q_a.size() == 0) checkOutput("unexpected_valid_a", 1, 0);
                else begin
                    e = q_a.pop_front();
                    checkOutput("x_a", int'(mx_a), e.x);
                    checkOutput("y_a", int'(my_a), e.y);
                    checkOutput("goal_a", int'(g_a), e.g);
                    checkOutput("latency_a", cyc, e.cyc);
                end
            end else if (g_a != 2'b00) checkOutput("stray_goal_a", int'(g_a), 0);
            if (pv_b) begin
                if (q_b.size() == 0) checkOutput("unexpected_valid_b", 1, 0);
                else begin
                    e = q_b.pop_front();
                    checkOutput("x_b", int'(mx_b), e.x);
                    checkOutput("y_b", int'(my_b), e.y);
                    checkOutput("goal_b", int'(g_b), e.g);
                    checkOutput("latency_b", cyc, e.cyc);
                end
            end else if (g_b != 2'b00) checkOutput("stray_goal_b", int'(g_b), 0);
        end
        if (done_chk && !done_seen) begin
            done_seen = 1'b1;
            checkOutput("drain_a", q_a.size(), 0);
            checkOutput("drain_b", q_b.size(), 0);
        end
    end

    // Directed scenarios followed by randomized kicks, ticks and resets.
    initial begin
        int wait_cnt;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle frames hold the serve position.
        repeat (10) applyStimulus();

        // Simultaneous kicks cancel, then a right kick.
        setButtons(2'b11);
        setButtons(2'b00);
        applyStimulus();
        setButtons(2'b01);
        setButtons(2'b00);
        repeat (85) applyStimulus();

        // Left kick into the goal mouth, kicks ignored while frozen.
        applyReset();
        setButtons(2'b10);
        setButtons(2'b00);
        repeat (79) applyStimulus();
        for (int i = 0; i < 60; i++) begin
            if (i % 10 == 3) begin
                setButtons(2'b01);
                setButtons(2'b00);
            end
            applyStimulus();
        end
        setButtons(2'b01);
        setButtons(2'b00);
        repeat (3) applyStimulus();

        // Reset landing mid-step discards the frame in progress.
        applyReset();
        setButtons(2'b01);
        setButtons(2'b00);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        repeat (2) applyStimulus();

        // Randomized play.
        for (int f = 0; f < 250; f++) begin
            int r;
            r = int'($urandom_range(0, 39));
            if (r == 0) applyReset();
            else if (r < 10) begin
                setButtons(2'($urandom_range(0, 3)));
                if ($urandom_range(0, 1) == 1) setButtons(2'b00);
            end
            applyStimulus();
        end

        wait_cnt = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && wait_cnt < 30) begin
            @(negedge clk);
            wait_cnt++;
        end
        done_chk = 1'b1;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
